// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Bundles the issue, MTHI/MTLO and result signals between the EX stage and the
// multiply/divide sequencer. clk and reset stay plain module ports.
//   master : EX-stage side (drives issue and writes, observes status/HI/LO)
//   slave  : sequencer side
// Signals: start, op[1:0], rs_data, rt_data, flush, hi_we, lo_we, wdata
//          (master -> slave); busy, done, hi, lo (slave -> master).
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU. Owns the HI/LO
// registers, runs one shift-add or restoring-divide step per cycle on operand
// magnitudes, then fixes up the signs in a final cycle.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous active-high reset
//   bus    : muldiv_sequencer_if.slave
//            op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//            busy (registered) is high in RUN and FIX; done pulses one cycle
//            after HI/LO are loaded with a result.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    muldiv_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Latched operation context
    logic             is_div_reg;
    logic             neg_q_reg;      // negate product / quotient
    logic             neg_r_reg;      // negate remainder
    logic             div_zero_reg;
    logic [WIDTH-1:0] raw_a_reg;      // dividend as issued, for divide by zero
    // Datapath: opnd = multiplicand or divisor magnitude;
    // {upper,lower} = product accumulator, or {remainder,quotient}.
    logic [WIDTH-1:0] opnd_reg, upper_reg, lower_reg;

    // Issue decode
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept = (state_reg == IDLE) && bus.start && !bus.flush;
    assign a_neg  = bus.op[0] & bus.rs_data[WIDTH-1];
    assign b_neg  = bus.op[0] & bus.rt_data[WIDTH-1];
    assign a_mag  = a_neg ? -bus.rs_data : bus.rs_data;
    assign b_mag  = b_neg ? -bus.rt_data : bus.rt_data;

    // Multiply step: conditional add into the upper half (one carry bit),
    // then shift the whole accumulator right by one.
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    assign mul_add = lower_reg[0] ? opnd_reg : '0;
    assign mul_sum = {1'b0, upper_reg} + {1'b0, mul_add};

    // Divide step: shift {rem,quot} left, trial-subtract the divisor. The
    // remainder is always below the divisor, so a successful difference
    // fits in WIDTH bits and modular subtraction gives it exactly.
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {upper_reg, lower_reg[WIDTH-1]};
    assign div_ok    = ({1'b0, opnd_reg} <= div_shift);
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;

    // Sign fix-up applied while in FIX
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;
    assign prod_mag = {upper_reg, lower_reg};
    assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;
    assign quot_fix = neg_q_reg ? -lower_reg : lower_reg;
    assign rem_fix  = neg_r_reg ? -upper_reg : upper_reg;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (div_zero_reg) begin
                res_hi = raw_a_reg;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quot_fix;
            end
        end
    end

    // FSM next-state and registered-output decode
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (bus.flush)                state_next = IDLE;
                else if (cnt_reg == LAST_CNT) state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                done_next  = !bus.flush;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            raw_a_reg    <= '0;
            opnd_reg     <= '0;
            upper_reg    <= '0;
            lower_reg    <= '0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
            case (state_reg)
                IDLE: begin
                    // MTHI/MTLO land even alongside an accepted start;
                    // the result of that operation overwrites them later.
                    if (bus.hi_we) hi_reg <= bus.wdata;
                    if (bus.lo_we) lo_reg <= bus.wdata;
                    if (accept) begin
                        cnt_reg      <= '0;
                        is_div_reg   <= bus.op[1];
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= (bus.rt_data == '0);
                        raw_a_reg    <= bus.rs_data;
                        upper_reg    <= '0;
                        if (bus.op[1]) begin
                            opnd_reg  <= b_mag;
                            lower_reg <= a_mag;
                        end else begin
                            opnd_reg  <= a_mag;
                            lower_reg <= b_mag;
                        end
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (is_div_reg) begin
                            upper_reg <= div_ok ? div_sub : div_shift[WIDTH-1:0];
                            lower_reg <= {lower_reg[WIDTH-2:0], div_ok};
                        end else begin
                            upper_reg <= mul_sum[WIDTH:1];
                            lower_reg <= {mul_sum[0], lower_reg[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Scoreboard bench: each accepted issue pushes the {hi,lo} expected from an
// arithmetic reference model; a monitor pops and compares on every done.
// Directed cases cover latency, corner operands, ignored starts, flush/reset
// aborts and MTHI/MTLO writes; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk;
    logic reset;
    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endfunction

    // Reference: plain integer arithmetic, returns {hi, lo}
    function automatic logic [63:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint unsigned up;
        longint          sp;
        int              sa, sb, q, r;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                return up;
            end
            2'b01: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 hi=%08h lo=%08h", bus.hi, bus.lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", bus.hi, e[63:32]);
                check("result_lo", bus.lo, e[31:0]);
                model_hi = e[63:32];
                model_lo = e[31:0];
                $display("txn done hi=%08h lo=%08h exp_hi=%08h exp_lo=%08h", bus.hi, bus.lo, e[63:32], e[31:0]);
            end
        end
    end

    // Drive an issue in the current (post-negedge) cycle; caller owns timing
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        exp_q.push_back(ref_model(op, a, b));
        $display("txn issue op=%0d rs=%08h rt=%08h", op, a, b);
    endtask

    // Walk cycles start_i.. after the issue edge until done (bounded)
    task automatic wait_result(input int start_i, input int busy0,
                               output int busy_cnt, output int done_at);
        busy_cnt = busy0;
        done_at  = 0;
        for (int i = start_i; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_at = i;
                break;
            end
        end
        if (done_at == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=none required=cycle_%0d", W + 2);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int bc, da;
        @(negedge clk);
        issue(op, a, b);
        wait_result(1, 0, bc, da);
        check("busy_cycles", bc, W + 1);
        check("done_cycle", da, W + 2);
    endtask

    initial begin
        int bc, da;
        logic seen_done;
        logic [31:0] ra, rb, lw;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);

        // Directed arithmetic corners
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'b10, 32'h0000_0064, 32'h0000_0000);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FF9C, 32'h0000_0000);

        // Second start while busy is ignored; new start in done cycle accepted
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'd7);
        da = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1)  bus.start = 1'b0;
            if (i == 10) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.rs_data = 32'd5; bus.rt_data = 32'd3;
            end
            if (i == 11) bus.start = 1'b0;
            if (bus.done) begin
                da = i;
                break;
            end
        end
        check("ignored_start_done_cycle", da, W + 2);
        issue(2'b01, 32'h0001_2345, 32'hFFFF_0006);
        wait_result(1, 0, bc, da);
        check("b2b_busy_cycles", bc, W + 1);
        check("b2b_done_cycle", da, W + 2);
        @(negedge clk);

        // Flush aborts: busy drops, no done, HI/LO untouched
        bus.hi_we = 1'b1; bus.wdata = 32'h1111_1111;
        @(negedge clk);
        bus.hi_we = 1'b0;
        model_hi = 32'h1111_1111;
        check("preload_hi", bus.hi, 32'h1111_1111);
        issue(2'b00, $urandom, $urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("flush_no_done", {31'd0, seen_done}, 0);
        check("flush_hi", bus.hi, model_hi);
        check("flush_lo", bus.lo, model_lo);

        // Reset mid-operation
        issue(2'b00, $urandom, $urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        check("rst_abort_busy", {31'd0, bus.busy}, 0);
        check("rst_abort_hi", bus.hi, 0);
        check("rst_abort_lo", bus.lo, 0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("rst_abort_no_done", {31'd0, seen_done}, 0);

        // MTHI while busy is ignored
        issue(2'b00, 32'd3, 32'd4);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 5) begin bus.hi_we = 1'b1; bus.wdata = 32'hABCD_0000; end
        end
        bus.hi_we = 1'b0;
        check("busy_write_hi", bus.hi, model_hi);
        wait_result(7, 0, bc, da);
        @(negedge clk);
        // MTHI/MTLO in IDLE
        bus.hi_we = 1'b1; bus.wdata = 32'hABCD_0000;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("idle_write_hi", bus.hi, 32'hABCD_0000);
        check("idle_write_lo_kept", bus.lo, model_lo);
        lw = $urandom;
        bus.lo_we = 1'b1; bus.wdata = lw;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("idle_write_lo", bus.lo, lw);

        // Write alongside an accepted start lands, then the result overwrites
        issue(2'b10, 32'd99, 32'd10);
        bus.hi_we = 1'b1; bus.wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("start_write_hi", bus.hi, 32'h5A5A_5A5A);
        wait_result(2, bus.busy ? 1 : 0, bc, da);
        check("start_write_done_cycle", da, W + 2);
        check("start_write_busy_cycles", bc, W + 1);

        // Randomized operations with biased corner operands
        repeat (40) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), ra, rb);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide sequencer beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU issue from EX and runs an iterative shift-add or restoring-divide datapath.
- Holds the architectural HI/LO registers and drives a stall to the pipeline controller while an operation is in flight.
- Services MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue request, sampled on the clock edge.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_data  in  WIDTH  operand A (multiplicand or dividend).
- rt_data  in  WIDTH  operand B (multiplier or divisor).
- flush  in  1  abort any in-flight operation (branch/exception squash).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  registered; high in RUN and FIX; the pipeline stalls while high.
- done  out  1  registered one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset overrides every other input, including an operation in progress.
- States: IDLE, RUN, FIX.
- IDLE, start=1, flush=0 at edge t:
  - Latch op and the operand magnitudes; for MULT/DIV take the absolute value of signed operands.
  - Record result signs:
    - product/quotient sign = sign(A) XOR sign(B), signed ops only;
    - remainder sign = sign(A).
  - Counter=0; go to RUN.
- RUN, one iteration per cycle for WIDTH cycles, counter 0..WIDTH-1:
  - Multiply: 2*WIDTH-bit shift-add accumulator. Examine the LSB of the multiplier; conditionally add the multiplicand into the upper half; shift right 1.
  - Divide: restoring division. Shift {rem,quot} left 1, subtract the divisor from rem. If non-negative, keep the difference and set quot LSB=1; else restore.
  - At counter=WIDTH-1, go to FIX.
- FIX, 1 cycle:
  - Apply the sign correction (two's-complement negate) to the 2*WIDTH product or to quotient/remainder independently.
  - Load hi/lo at the edge leaving FIX:
    - multiply: hi=upper half, lo=lower half;
    - divide: hi=remainder, lo=quotient.
  - Go to IDLE; done=1 for exactly the next cycle.
- Latency: start sampled at edge t; busy high for cycles t+1..t+WIDTH+1 (WIDTH+1 cycles); done high in cycle t+WIDTH+2, when hi/lo already hold the result.
- start while busy=1 is ignored; there is no queueing.
- start in the done cycle (state IDLE) is accepted normally.
- Divide by zero, both DIVU and DIV: lo=all ones, hi=rs_data as issued (raw dividend). No exception is raised. The same latency applies.
- DIV of the most negative value by -1: lo=most negative value, hi=0. No trap.
- flush=1 in RUN or FIX: next state IDLE, busy=0. hi/lo are unchanged and no done pulse follows.
- flush=1 in IDLE: no effect. flush and start together in IDLE: start is dropped.
- hi_we/lo_we:
  - In IDLE: write wdata at the edge.
  - While busy=1: ignored.
  - hi_we/lo_we together with an accepted start: the write takes effect, and the eventual result overwrites it.
- The iteration datapath is internal; hi/lo change only on reset, a FIX completion, or an IDLE write.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 33 cycles; done in cycle 34 after start; hi=0x00000001, lo=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3), rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=0x00000064, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064, done after the normal latency. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU, assert start again with different operands at cycle 10 -> second request ignored; result matches the first operands only. Issue a new start in the done cycle -> accepted; busy rises in the next cycle.
- Preload hi=0x11111111 via hi_we, start MULTU, assert flush at cycle 20 -> busy=0 in the next cycle; no done; hi still 0x11111111. Repeat with reset instead of flush -> hi=lo=0.
- hi_we=1 with wdata=0xABCD0000 while busy -> hi unchanged. Same write in IDLE -> hi=0xABCD0000 at the next edge.
